// File: rtl/i2s_in_if.sv
// rtl/i2s_in_if.sv - I2S receiver pin bundle: serial inputs from the source, parallel sample pair back.
// master = I2S source / sample consumer side, slave = i2s_in.
interface i2s_in_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  d_in;
  logic                  ws_in;
  logic                  bclk_in;
  logic [DATA_WIDTH-1:0] left_out;
  logic [DATA_WIDTH-1:0] right_out;
  logic                  data_valid_out;
  logic                  frame_error_out;

  modport master (
    output d_in,
    output ws_in,
    output bclk_in,
    input  left_out,
    input  right_out,
    input  data_valid_out,
    input  frame_error_out
  );

  modport slave (
    input  d_in,
    input  ws_in,
    input  bclk_in,
    output left_out,
    output right_out,
    output data_valid_out,
    output frame_error_out
  );
endinterface

// File: rtl/i2s_in.sv
// rtl/i2s_in.sv - I2S receiver: syncs bclk/ws/data into clk_in, delivers left/right pairs with a valid strobe.
// Optional slot-length check: define I2S_IN_FRAME_CHECK_EN.
module i2s_in #(
  parameter int DATA_WIDTH = 16
) (
  input  logic   clk_in,
  input  logic   reset_in,
  i2s_in_if.slave bus
);
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ARMING   = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  logic d_meta, d_s;
  logic ws_meta, ws_s;
  logic bclk_meta, bclk_s, bclk_d;

  logic [1:0]            state;
  logic                  ws_prev;
  logic [5:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  left_ok;
  logic [DATA_WIDTH-1:0] left_q;
  logic [DATA_WIDTH-1:0] right_q;
  logic                  valid_q;
  logic                  ferr_q;

  logic bclk_rise;
  logic boundary;
  logic slot_err;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      d_meta    <= 1'b0;
      d_s       <= 1'b0;
      ws_meta   <= 1'b0;
      ws_s      <= 1'b0;
      bclk_meta <= 1'b0;
      bclk_s    <= 1'b0;
      bclk_d    <= 1'b0;
    end else begin
      d_meta    <= bus.d_in;
      d_s       <= d_meta;
      ws_meta   <= bus.ws_in;
      ws_s      <= ws_meta;
      bclk_meta <= bus.bclk_in;
      bclk_s    <= bclk_meta;
      bclk_d    <= bclk_s;
    end
  end

  assign bclk_rise = bclk_s & ~bclk_d;
  // Word as it stands including the bit sampled on this edge (the one-bit-delay LSB).
  assign shifted   = {shift_reg[DATA_WIDTH-2:0], d_s};
  assign boundary  = (state != ST_UNLOCKED) && (ws_s != ws_prev);

`ifdef I2S_IN_FRAME_CHECK_EN
  localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);
  assign slot_err = (bit_cnt != LAST_BIT);
`else
  assign slot_err = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state     <= ST_UNLOCKED;
      ws_prev   <= 1'b0;
      bit_cnt   <= 6'd0;
      shift_reg <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bclk_rise) begin
        shift_reg <= shifted;
        ws_prev   <= ws_s;
        if (boundary) begin
          bit_cnt <= 6'd0;
        end else if (bit_cnt != 6'h3f) begin
          bit_cnt <= bit_cnt + 6'd1;
        end

        case (state)
          ST_UNLOCKED: state <= ST_ARMING;
          ST_ARMING: begin
            if (boundary) state <= ST_RUN;
          end
          ST_RUN: begin
            if (boundary) begin
              if (slot_err) begin
                ferr_q  <= 1'b1;
                left_ok <= 1'b0;
              end else if (!ws_prev) begin
                left_hold <= shifted;
                left_ok   <= 1'b1;
              end else if (left_ok) begin
                left_q  <= left_hold;
                right_q <= shifted;
                valid_q <= 1'b1;
                left_ok <= 1'b0;
              end
            end
          end
          default: state <= ST_UNLOCKED;
        endcase
      end
    end
  end

  assign bus.left_out        = left_q;
  assign bus.right_out       = right_q;
  assign bus.data_valid_out  = valid_q;
  assign bus.frame_error_out = ferr_q;
endmodule

// File: tb/tb_i2s_in.sv
// tb/tb_i2s_in.sv - scoreboard bench for i2s_in driven by a behavioural 32fs I2S source.
module tb_i2s_in;
  localparam int DW = 16;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;

  i2s_in_if #(.DATA_WIDTH(DW)) bus ();

  i2s_in #(.DATA_WIDTH(DW)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;
  int pushed = 0;
  int fe_count = 0;
  int exp_fe = 0;
  int rise_cnt = 0;
  logic bclk_tb_prev = 1'b0;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0] hold_l, hold_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Clock edges since the bclk pin was last seen rising (1 = edge that first sampled it).
  always @(posedge clk_in) begin
    if (bus.bclk_in && !bclk_tb_prev) rise_cnt <= 1;
    else if (rise_cnt < 100000) rise_cnt <= rise_cnt + 1;
    bclk_tb_prev <= bus.bclk_in;
  end

  always @(negedge clk_in) begin
    if (bus.data_valid_out === 1'b1) begin
      logic [2*DW-1:0] e;
      strobe_count++;
      check("dv_width", dv_prev, 1'b0);
      check("dv_latency", rise_cnt, 3);
      check("dv_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("left", bus.left_out, e[2*DW-1:DW]);
        check("right", bus.right_out, e[DW-1:0]);
      end
    end
    if (bus.frame_error_out === 1'b1) begin
      fe_count++;
      check("fe_width", fe_prev, 1'b0);
    end
    dv_prev = bus.data_valid_out;
    fe_prev = bus.frame_error_out;
  end

  task automatic send_bit(input logic ws, input logic d);
    bus.ws_in = ws;
    bus.d_in  = d;
    repeat (3) @(negedge clk_in);
    bus.bclk_in = 1'b1;
    repeat (3) @(negedge clk_in);
    bus.bclk_in = 1'b0;
  endtask

  // Bits hi..lo of a slot, MSB first; ws flips on bit 0 (one-bit delay).
  task automatic send_range(input logic ws_slot, input logic [31:0] word, input int hi, input int lo);
    for (int j = hi; j >= lo; j--) send_bit((j == 0) ? ~ws_slot : ws_slot, word[j]);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    exp_q.push_back({l, r});
    pushed++;
    send_range(1'b0, 32'(l), DW-1, 0);
    send_range(1'b1, 32'(r), DW-1, 0);
  endtask

  initial begin
    bus.d_in = 1'b0;
    bus.ws_in = 1'b0;
    bus.bclk_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("rst_left", bus.left_out, 0);
    check("rst_right", bus.right_out, 0);
    check("rst_dv", bus.data_valid_out, 0);
    check("rst_fe", bus.frame_error_out, 0);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // Join mid-left-slot: partial frame must not strobe.
    send_range(1'b0, 32'hFFFF, 5, 0);
    send_range(1'b1, 32'h5A5A, DW-1, 0);
    send_frame(16'h1234, 16'hABCD);
    send_frame(16'h8000, 16'h7FFF);

    // Reset in the middle of the right slot.
    send_range(1'b0, 32'h1111, DW-1, 0);
    send_range(1'b1, 32'h2222, DW-1, 8);
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("mid_rst_left", bus.left_out, 0);
    check("mid_rst_right", bus.right_out, 0);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("post_rst_left", bus.left_out, 0);
    check("post_rst_right", bus.right_out, 0);
    send_range(1'b1, 32'h0, 3, 0);
    send_frame(16'h0F0F, 16'hF0F0);

`ifdef I2S_IN_FRAME_CHECK_EN
    send_range(1'b0, 32'h1234, DW-2, 0);
    send_range(1'b1, 32'h5678, DW-1, 0);
    exp_fe++;
    send_frame(16'h5555, 16'hAAAA);
    hold_l = 16'h5555;
    hold_r = 16'hAAAA;
`else
    exp_q.push_back({16'h3456, 16'hCDEF});
    pushed++;
    send_range(1'b0, 32'h123456, 23, 0);
    send_range(1'b1, 32'hABCDEF, 23, 0);
    send_frame(16'h5555, 16'hAAAA);
    hold_l = 16'h5555;
    hold_r = 16'hAAAA;
`endif

    // bclk halted mid right slot.
    exp_q.push_back({16'h4321, 16'h8765});
    pushed++;
    send_range(1'b0, 32'h4321, DW-1, 0);
    send_range(1'b1, 32'h8765, DW-1, 8);
    repeat (1000) @(negedge clk_in);
    check("halt_left", bus.left_out, hold_l);
    check("halt_right", bus.right_out, hold_r);
    check("halt_pending", exp_q.size(), 1);
    send_range(1'b1, 32'h8765, 7, 0);

    repeat (20) @(negedge clk_in);
    check("queue_empty", exp_q.size(), 0);
    check("strobe_count", strobe_count, pushed);
    check("fe_count", fe_count, exp_fe);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
